async_mem_burst_master: RTL

ASYNC_MEM_BURST_MASTER -- requirements
Module: async_mem_burst_master

---
 rtl/async_mem_burst_master.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/async_mem_burst_master.sv
// Burst master for an asynchronous SRAM-style bus: CS/OE/WE/byte-lane strobes
// with programmable setup/hold timing, multi-beat bursts and read compare.
module async_mem_burst_master #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int CE_SETUP  = 10,
  parameter int OP_HOLD   = 15,
  parameter int LEN_W     = 4,
  parameter int ADDR_STEP = DW/8
) (
  input  logic              tb_clk,
  input  logic              tb_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_cmp,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DW/8-1:0]   cmd_bls_n,
  input  logic [DW-1:0]     wr_data,
  output logic              wr_beat,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  input  logic [DW-1:0]     rd_exp,
  output logic [15:0]       cmp_err_cnt,
  output logic              busy,
  inout  wire  [DW-1:0]     mem_d,
  output logic [AW-1:0]     mem_a,
  output logic              mem_oe_n,
  output logic [DW/8-1:0]   mem_bls_n,
  output logic              mem_we_n,
  output logic              mem_cs_n
);
  typedef enum logic [2:0] {IDLE, SETUP, WR_PULSE, WR_RECOV, RD_ACCESS, RD_HOLD, END} state_t;

  typedef struct packed {
    logic             write;
    logic             cmp;
    logic [LEN_W-1:0] len;
    logic [DW/8-1:0]  bls_n;
  } cmd_t;

  localparam int CMAX = (CE_SETUP > OP_HOLD) ? CE_SETUP : OP_HOLD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CE_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(OP_HOLD - 1);
  localparam logic [AW-1:0] STEP       = AW'(ADDR_STEP);

  state_t           state;
  cmd_t             cmd_q;
  logic [CW-1:0]    cnt;
  logic [LEN_W-1:0] beat;
  logic [AW-1:0]    beat_addr;
  logic [DW-1:0]    dout;
  logic             drive;

  logic          last_cyc, last_beat, miscmp;
  logic [AW-1:0] next_addr;

  assign last_cyc  = (cnt == '0);
  assign last_beat = (beat == cmd_q.len);
  assign next_addr = beat_addr + STEP;
  // Undriven or unknown bus bits must count as a miscompare.
  assign miscmp    = (mem_d !== rd_exp);
  assign mem_d     = drive ? dout : 'z;

  always_ff @(posedge tb_clk) begin
    if (tb_rst) begin
      state       <= IDLE;
      cmd_q       <= '0;
      cnt         <= '0;
      beat        <= '0;
      beat_addr   <= '0;
      dout        <= '0;
      drive       <= 1'b0;
      mem_a       <= '0;
      mem_cs_n    <= 1'b1;
      mem_oe_n    <= 1'b1;
      mem_we_n    <= 1'b1;
      mem_bls_n   <= '1;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      wr_beat     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      cmp_err_cnt <= '0;
    end else begin
      wr_beat  <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_q     <= '{write: cmd_write, cmp: cmd_cmp, len: cmd_len, bls_n: cmd_bls_n};
            beat      <= '0;
            beat_addr <= cmd_addr;
            cnt       <= SETUP_LAST;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            mem_cs_n  <= 1'b0;
            if (cmd_write) begin
              state <= SETUP;
            end else begin
              state     <= RD_ACCESS;
              mem_oe_n  <= 1'b0;
              mem_a     <= cmd_addr;
              mem_bls_n <= cmd_bls_n;
            end
          end
        end
        SETUP, WR_RECOV: begin
          if (last_cyc) begin
            state     <= WR_PULSE;
            cnt       <= HOLD_LAST;
            mem_we_n  <= 1'b0;
            mem_bls_n <= cmd_q.bls_n;
            mem_a     <= beat_addr;
            dout      <= wr_data;
            drive     <= 1'b1;
            wr_beat   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_PULSE: begin
          if (last_cyc) begin
            mem_we_n <= 1'b1;
            if (last_beat) begin
              state <= END;
            end else begin
              // mem_a and data stay on the bus through recovery
              state     <= WR_RECOV;
              cnt       <= SETUP_LAST;
              beat      <= beat + 1'b1;
              beat_addr <= next_addr;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_ACCESS: begin
          if (last_cyc) begin
            state    <= RD_HOLD;
            cnt      <= HOLD_LAST;
            rd_data  <= mem_d;
            rd_valid <= 1'b1;
            if (cmd_q.cmp && miscmp && cmp_err_cnt != 16'hFFFF)
              cmp_err_cnt <= cmp_err_cnt + 16'd1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_HOLD: begin
          if (last_cyc) begin
            if (last_beat) begin
              state    <= END;
              mem_oe_n <= 1'b1;
            end else begin
              state     <= RD_ACCESS;
              cnt       <= SETUP_LAST;
              beat      <= beat + 1'b1;
              beat_addr <= next_addr;
              mem_a     <= next_addr;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        END: begin
          state     <= IDLE;
          drive     <= 1'b0;
          mem_a     <= '0;
          mem_cs_n  <= 1'b1;
          mem_oe_n  <= 1'b1;
          mem_we_n  <= 1'b1;
          mem_bls_n <= '1;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
